// File: rtl/btisa_decode_stage.sv
// btisa_decode_stage
//   Registered, handshaked decode stage between fetch and execute of the
//   balanced-ternary BTISA pipeline. Each accepted instruction word is split
//   into opcode/rd/rs1/rs2_imm and decoded into the execute control bundle,
//   then queued in a 2-entry FIFO skid buffer whose head drives the outputs.
//
//   Trit encoding (2 bits per trit): 2'b00 = 0, 2'b01 = +, 2'b10 = -,
//   2'b11 = invalid. A trit vector [N-1:0] occupies bits [2N-1:0], with
//   trit k in bits [2k+1:2k].
//
//   Optional feature macro: BTISA_MUL_EN. When defined, MUL decodes to
//   alu_op 3'b111; otherwise MUL decodes to alu_op 3'b000 (ADD).
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  fetch handshake (in_ready is a register)
//   in_instr           instruction word, opcode/rd/rs1/rs2_imm MSB first
//   flush              discard all buffered entries
//   resume             leave HALTED
//   out_valid/out_ready execute handshake
//   out_opcode, out_rd, out_rs1, out_rs2_imm   decoded fields
//   out_reg_write .. out_illegal, out_alu_op   control bundle
//   halted             FSM is in HALTED
//   issue_cnt          count of delivered entries, wraps at 2^CNT_W
module btisa_decode_stage #(
  parameter int REG_TRITS = 2,
  parameter int IMM_TRITS = 2,
  parameter int CNT_W     = 16,
  localparam int ILEN     = 3 + 2*REG_TRITS + IMM_TRITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*ILEN-1:0]      in_instr,
  input  logic                   flush,
  input  logic                   resume,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_opcode,
  output logic [2*REG_TRITS-1:0] out_rd,
  output logic [2*REG_TRITS-1:0] out_rs1,
  output logic [2*IMM_TRITS-1:0] out_rs2_imm,
  output logic                   out_reg_write,
  output logic                   out_mem_read,
  output logic                   out_mem_write,
  output logic                   out_branch,
  output logic                   out_jump,
  output logic                   out_alu_src,
  output logic                   out_halt,
  output logic                   out_illegal,
  output logic [2:0]             out_alu_op,
  output logic                   halted,
  output logic [CNT_W-1:0]       issue_cnt
);

  localparam logic [1:0] TZ = 2'b00;
  localparam logic [1:0] TP = 2'b01;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TX = 2'b11;

`ifdef BTISA_MUL_EN
  localparam logic [2:0] MUL_ALU_OP = 3'b111;
`else
  localparam logic [2:0] MUL_ALU_OP = 3'b000;
`endif

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [5:0]             opcode;
    logic [2*REG_TRITS-1:0] rd;
    logic [2*REG_TRITS-1:0] rs1;
    logic [2*IMM_TRITS-1:0] imm;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   branch;
    logic                   jump;
    logic                   alu_src;
    logic                   halt;
    logic                   illegal;
    logic [2:0]             alu_op;
  } entry_t;

  entry_t     dec;
  entry_t     slot0;
  entry_t     slot1;
  logic [1:0] occ;
  logic [1:0] occ_next;
  state_t     state;
  state_t     state_next;
  logic       accept;
  logic       deliver;

  // Field split and control decode of the word currently presented by fetch.
  always_comb begin
    dec        = '0;
    dec.opcode = in_instr[2*ILEN-1 -: 6];
    dec.rd     = in_instr[2*ILEN-7 -: 2*REG_TRITS];
    dec.rs1    = in_instr[2*ILEN-7-2*REG_TRITS -: 2*REG_TRITS];
    dec.imm    = in_instr[2*IMM_TRITS-1:0];
    if ((dec.opcode[5:4] == TX) || (dec.opcode[3:2] == TX) || (dec.opcode[1:0] == TX)) begin
      dec.illegal = 1'b1;
    end else begin
      case (dec.opcode)
        // arithmetic
        {TZ, TZ, TZ}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b000; end
        {TZ, TZ, TP}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b001; end
        {TZ, TZ, TN}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b010; end
        {TZ, TP, TZ}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = MUL_ALU_OP; end
        {TZ, TP, TP}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b101; end
        {TZ, TP, TN}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b110; end
        // branch
        {TZ, TN, TZ},
        {TZ, TN, TP},
        {TZ, TN, TN}: begin dec.branch = 1'b1; dec.alu_op = 3'b001; end
        // logic
        {TP, TZ, TZ}: begin dec.reg_write = 1'b1; dec.alu_op = 3'b011; end
        {TP, TZ, TP}: begin dec.reg_write = 1'b1; dec.alu_op = 3'b100; end
        {TP, TZ, TN}: begin dec.reg_write = 1'b1; dec.alu_op = 3'b000; end
        {TP, TP, TZ},
        {TP, TP, TP},
        {TP, TP, TN}: begin dec.reg_write = 1'b1; dec.alu_op = 3'b010; end
        // jump
        {TP, TN, TZ},
        {TP, TN, TP}: begin dec.jump = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
        {TP, TN, TN}: begin dec.jump = 1'b1; dec.alu_src = 1'b1; end
        // memory
        {TN, TZ, TZ},
        {TN, TZ, TN}: begin dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src = 1'b1; end
        {TN, TZ, TP},
        {TN, TP, TZ}: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
        {TN, TP, TP}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
        {TN, TP, TN}: dec.illegal = 1'b1;
        // system
        {TN, TN, TP}: dec.halt = 1'b1;
        default: ;  // NOP, ECALL
      endcase
    end
  end

  assign out_valid = (occ != 2'd0);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign halted    = (state == HALTED);

  // Next occupancy/state are computed ahead so in_ready can be registered
  // and still reflect this cycle's accept/deliver/halt.
  always_comb begin
    occ_next   = occ;
    state_next = state;
    if (flush) begin
      occ_next = 2'd0;
    end else begin
      case ({accept, deliver})
        2'b10:   occ_next = occ + 2'd1;
        2'b01:   occ_next = occ - 2'd1;
        default: ;
      endcase
      if ((state == RUN) && accept && dec.halt) state_next = HALTED;
    end
    if ((state == HALTED) && resume) state_next = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      state     <= RUN;
      in_ready  <= 1'b1;
      slot0     <= '0;
      slot1     <= '0;
      issue_cnt <= '0;
    end else begin
      occ      <= occ_next;
      state    <= state_next;
      in_ready <= (occ_next != 2'd2) && (state_next == RUN);
      if (deliver && !flush) issue_cnt <= issue_cnt + 1'b1;
      if (!flush) begin
        // slot0 is always the head; slot1 only holds a second entry.
        case ({accept, deliver})
          2'b10: begin
            if (occ == 2'd0) slot0 <= dec;
            else             slot1 <= dec;
          end
          2'b01:   slot0 <= slot1;
          2'b11:   slot0 <= dec;  // occupancy is 1 here, head replaced
          default: ;
        endcase
      end
    end
  end

  assign out_opcode    = slot0.opcode;
  assign out_rd        = slot0.rd;
  assign out_rs1       = slot0.rs1;
  assign out_rs2_imm   = slot0.imm;
  assign out_reg_write = slot0.reg_write;
  assign out_mem_read  = slot0.mem_read;
  assign out_mem_write = slot0.mem_write;
  assign out_branch    = slot0.branch;
  assign out_jump      = slot0.jump;
  assign out_alu_src   = slot0.alu_src;
  assign out_halt      = slot0.halt;
  assign out_illegal   = slot0.illegal;
  assign out_alu_op    = slot0.alu_op;

endmodule

// File: tb/tb_btisa_decode_stage.sv
// Testbench for btisa_decode_stage: scoreboard of expected decoded entries,
// pushed on acceptance and popped on delivery, plus per-cycle handshake,
// halt and issue-count checks. A second 3/3-trit instance checks the field
// split on a 12-trit word.
module tb_btisa_decode_stage;

  localparam int R = 2;
  localparam int I = 2;
  localparam int W = 2*(3 + 2*R + I);
  localparam int EW = W + 11;

`ifdef BTISA_MUL_EN
  localparam logic [2:0] MUL_OP = 3'b111;
`else
  localparam logic [2:0] MUL_OP = 3'b000;
`endif

  // {opcode, flags{reg_write,mem_read,mem_write,branch,jump,alu_src,halt,illegal}, alu_op}
  localparam logic [16:0] TBL [27] = '{
    {6'b000000, 8'b10000100, 3'b000},  // ADD
    {6'b000001, 8'b10000100, 3'b001},  // SUB
    {6'b000010, 8'b10000100, 3'b010},  // NEG
    {6'b000100, 8'b10000100, MUL_OP},  // MUL
    {6'b000101, 8'b10000100, 3'b101},  // SHL
    {6'b000110, 8'b10000100, 3'b110},  // SHR
    {6'b001000, 8'b00010000, 3'b001},  // BEQ
    {6'b001001, 8'b00010000, 3'b001},  // BNE
    {6'b001010, 8'b00010000, 3'b001},  // BLT
    {6'b010000, 8'b10000000, 3'b011},  // MIN
    {6'b010001, 8'b10000000, 3'b100},  // MAX
    {6'b010010, 8'b10000000, 3'b000},  // XOR
    {6'b010100, 8'b10000000, 3'b010},  // INV
    {6'b010101, 8'b10000000, 3'b010},  // PTI
    {6'b010110, 8'b10000000, 3'b010},  // NTI
    {6'b011000, 8'b10001100, 3'b000},  // JAL
    {6'b011001, 8'b10001100, 3'b000},  // JALR
    {6'b011010, 8'b00001100, 3'b000},  // JR
    {6'b100000, 8'b11000100, 3'b000},  // LD
    {6'b100001, 8'b00100100, 3'b000},  // ST
    {6'b100010, 8'b11000100, 3'b000},  // LDT
    {6'b100100, 8'b00100100, 3'b000},  // STT
    {6'b100101, 8'b10000100, 3'b000},  // LUI
    {6'b100110, 8'b00000001, 3'b000},  // -+- illegal
    {6'b101000, 8'b00000000, 3'b000},  // NOP
    {6'b101001, 8'b00000010, 3'b000},  // HALT
    {6'b101010, 8'b00000000, 3'b000}   // ECALL
  };
  localparam logic [5:0] OP_HALT = 6'b101001;
  localparam logic [5:0] OP_ADD  = 6'b000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, in_valid = 1'b0, flush = 1'b0, resume = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [W-1:0]  in_instr = '0;
  logic [5:0]    out_opcode;
  logic [2*R-1:0] out_rd, out_rs1;
  logic [2*I-1:0] out_rs2_imm;
  logic          out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump;
  logic          out_alu_src, out_halt, out_illegal, halted;
  logic [2:0]    out_alu_op;
  logic [15:0]   issue_cnt;

  btisa_decode_stage #(.REG_TRITS(R), .IMM_TRITS(I), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .resume(resume), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2_imm(out_rs2_imm),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump), .out_alu_src(out_alu_src),
    .out_halt(out_halt), .out_illegal(out_illegal), .out_alu_op(out_alu_op),
    .halted(halted), .issue_cnt(issue_cnt)
  );

  // 3/3-trit instance: 12-trit word
  logic        in3_valid = 1'b0, in3_ready, out3_valid;
  logic [23:0] in3_instr = '0;
  logic [5:0]  out3_opcode, out3_rd, out3_rs1, out3_imm;
  logic        out3_reg_write, out3_mem_read, out3_mem_write, out3_branch, out3_jump;
  logic        out3_alu_src, out3_halt, out3_illegal, halted3;
  logic [2:0]  out3_alu_op;
  logic [7:0]  issue3_cnt;

  btisa_decode_stage #(.REG_TRITS(3), .IMM_TRITS(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in3_valid), .in_ready(in3_ready), .in_instr(in3_instr),
    .flush(1'b0), .resume(1'b0), .out_valid(out3_valid), .out_ready(1'b1),
    .out_opcode(out3_opcode), .out_rd(out3_rd), .out_rs1(out3_rs1), .out_rs2_imm(out3_imm),
    .out_reg_write(out3_reg_write), .out_mem_read(out3_mem_read), .out_mem_write(out3_mem_write),
    .out_branch(out3_branch), .out_jump(out3_jump), .out_alu_src(out3_alu_src),
    .out_halt(out3_halt), .out_illegal(out3_illegal), .out_alu_op(out3_alu_op),
    .halted(halted3), .issue_cnt(issue3_cnt)
  );

  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  logic [EW-1:0]   sb[$];
  logic [EW-1:0]   cur_exp = '0;
  logic [15:0]     exp_cnt = '0;
  bit              m_halted = 1'b0;
  bit              acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ctl_of(input logic [5:0] op);
    logic [10:0] r;
    r = 11'b00000001_000;  // any opcode not in the map carries an invalid trit
    for (int unsigned k = 0; k < 27; k++) begin
      logic [16:0] e;
      e = TBL[k];
      if (e[16:11] == op) r = e[10:0];
    end
    return r;
  endfunction

  function automatic logic [1:0] rtrit();
    case ($urandom_range(0, 2))
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [W-1:0] mkword(input logic [5:0] op);
    logic [W-7:0] f;
    for (int unsigned k = 0; k < (W-6)/2; k++) f[2*k +: 2] = rtrit();
    return {op, f};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {out_opcode, out_rd, out_rs1, out_rs2_imm, out_reg_write, out_mem_read,
            out_mem_write, out_branch, out_jump, out_alu_src, out_halt, out_illegal, out_alu_op};
  endfunction

  task automatic present(input logic [W-1:0] w);
    in_instr = w;
    cur_exp  = {w, ctl_of(w[W-1 -: 6])};
    in_valid = 1'b1;
  endtask

  // One clock: observe handshakes at the falling edge, then check state
  // 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    acc = 1'b0;
    if (rst) begin
      sb.delete();
      exp_cnt  = '0;
      m_halted = 1'b0;
    end else if (flush) begin
      sb.delete();
      if (resume && m_halted) m_halted = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else check("entry", 64'(obs()), 64'(sb.pop_front()));
        exp_cnt++;
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        sb.push_back(cur_exp);
        if (in_instr[W-1 -: 6] == OP_HALT) m_halted = 1'b1;
      end else if (resume && m_halted) begin
        m_halted = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("issue_cnt", 64'(issue_cnt), 64'(exp_cnt));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("in_ready", 64'(in_ready), 64'(sb.size() < 2 && !m_halted));
    check("halted", 64'(halted), 64'(m_halted));
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    present(w);
    acc = 1'b0;
    while (!acc && n < 20) begin
      tick();
      n++;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w1, w2, w3, wadd;
    int c0;
    bit got;

    // reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_fields", 64'(obs()), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    // 3/3 field split on a 12-trit word: ADD rd=+0- rs1=-0+ imm=+-0
    check("w3_ready", 64'(in3_ready), 64'd1);
    in3_instr = {6'b000000, 6'b010010, 6'b100001, 6'b011000};
    in3_valid = 1'b1;
    tick();
    in3_valid = 1'b0;
    check("w3_valid", 64'(out3_valid), 64'd1);
    check("w3_rd", 64'(out3_rd), 64'h12);
    check("w3_rs1", 64'(out3_rs1), 64'h21);
    check("w3_imm", 64'(out3_imm), 64'h18);
    check("w3_ctl", 64'({out3_reg_write, out3_alu_src, out3_alu_op}), 64'b11_000);

    // ADD rd=+0 rs1=-+ imm=0-, one-cycle latency
    out_ready = 1'b1;
    send({6'b000000, 4'b0100, 4'b1001, 4'b0010});
    in_valid = 1'b0;
    check("add_rd", 64'(out_rd), 64'h4);
    check("add_rs1", 64'(out_rs1), 64'h9);
    check("add_imm", 64'(out_rs2_imm), 64'h2);
    check("add_ctl", 64'({out_reg_write, out_alu_src, out_alu_op}), 64'b11_000);
    tick();
    check("add_cnt", 64'(issue_cnt), 64'd1);

    // stream every opcode except HALT back-to-back
    c0 = cyc;
    for (int unsigned k = 0; k < 27; k++) begin
      logic [16:0] e;
      e = TBL[k];
      if (e[16:11] != OP_HALT) send(mkword(e[16:11]));
    end
    check("stream_cycles", 64'(cyc - c0), 64'd26);
    in_valid = 1'b0;
    repeat (3) tick();

    // back-pressure: two accepted, third held until execute drains
    out_ready = 1'b0;
    w1 = mkword(6'b001000);
    w2 = mkword(6'b011000);
    w3 = mkword(6'b100001);
    send(w1);
    send(w2);
    present(w3);
    got = 1'b0;
    repeat (2) begin tick(); got |= acc; end
    check("full_block", 64'(got), 64'd0);
    out_ready = 1'b1;
    send(w3);
    in_valid = 1'b0;
    repeat (4) tick();

    // HALT then ADD: ADD held until resume
    send(mkword(OP_HALT));
    wadd = mkword(OP_ADD);
    present(wadd);
    got = 1'b0;
    repeat (3) begin tick(); got |= acc; end
    check("halt_block", 64'(got), 64'd0);
    check("halt_state", 64'(halted), 64'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    send(wadd);
    in_valid = 1'b0;
    repeat (3) tick();

    // opcode with an invalid trit
    send({6'b110000, 12'h000});
    in_valid = 1'b0;
    repeat (2) tick();

    // flush with two entries
    out_ready = 1'b0;
    send(w1);
    send(w2);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    tick();

    // flush discards an in-cycle accept
    send(w1);
    present(w2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_acc", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();

    // reset mid-operation, with flush also asserted
    out_ready = 1'b0;
    send(w3);
    in_valid = 1'b0;
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_cnt", 64'(issue_cnt), 64'd0);
    out_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
